// File: rtl/sample_dumper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_dumper_pkg
//  Description : Values shared by the sampler, the sample dumper and the UART
//                receiver: capture buffer depth, sample width and the default
//                UART bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_dumper_pkg;

  // Depth of the sampler capture buffer; a complete dump walks this many words.
  localparam int SAMPLER_DEPTH = 2048;

  // Width of one captured sample word.
  localparam int SAMPLE_WIDTH = 8;

  // System clock cycles per UART bit (100 MHz / 115200 baud).
  localparam int UART_CLKS_PER_BIT = 868;

endpackage : sample_dumper_pkg
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : UART transmitter for one frame: start bit (0), DATA_SIZE data
//                bits LSB first, stop bit (1). Each bit lasts CLKS_PER_BIT
//                clocks.
//  Ports       : i_clock  - system clock
//                i_reset  - asynchronous active-high reset
//                i_start  - begin a frame with i_data (accepted when not busy)
//                i_data   - word to send
//                o_tx     - registered serial line, idle high
//                o_busy   - frame in progress
//                o_done   - high during the final stop-bit clock
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import sample_dumper_pkg::*;
#(
  parameter int DATA_SIZE    = SAMPLE_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_SIZE + 2);

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  // Frame slot numbering: 0 = start, 1..DATA_SIZE = data, DATA_SIZE+1 = stop.
  localparam logic [BIT_W-1:0]  c_last_data = BIT_W'(DATA_SIZE);
  localparam logic [BIT_W-1:0]  c_stop      = BIT_W'(DATA_SIZE + 1);

  logic                 busy_q;
  logic                 tx_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_SIZE-1:0] shift_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (!busy_q) begin
      if (i_start) begin
        busy_q  <= 1'b1;
        tx_q    <= 1'b0;
        shift_q <= i_data;
        baud_q  <= '0;
        bit_q   <= '0;
      end
    end else if (baud_q != c_baud_last) begin
      baud_q <= baud_q + 1'b1;
    end else begin
      baud_q <= '0;
      if (bit_q == c_stop) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        bit_q <= bit_q + 1'b1;
        // Leaving the start bit or a data bit: shift the next data bit out;
        // leaving the last data bit: drive the stop level.
        if (bit_q < c_last_data) begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end else begin
          tx_q <= 1'b1;
        end
      end
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = busy_q && (bit_q == c_stop) && (baud_q == c_baud_last);

endmodule : uart_tx_byte
`default_nettype wire

// File: rtl/sample_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : sample_dumper
//  Description : Walks the frozen sampler buffer using the next/valid/idle
//                handshake and sends each word as one UART frame.
//  Ports       : i_clock, i_reset (async, active high)
//                i_start  - dump request level, sampled only when idle
//                i_data   - sampler word; i_valid - word present
//                i_idle   - sampler released / no readout in progress
//                o_next   - one-cycle advance pulse to the sampler
//                o_tx     - UART line, idle high
//                o_busy   - dump in progress; o_done - one-cycle end pulse
//                o_count  - words sent in the current/last dump
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_dumper
  import sample_dumper_pkg::*;
#(
  parameter int DATA_SIZE    = SAMPLE_WIDTH,
  parameter int NUM_SAMPLES  = SAMPLER_DEPTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 i_idle,
  output logic                 o_next,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_count
);

  localparam logic [2:0] c_idle       = 3'd0;
  localparam logic [2:0] c_wait_valid = 3'd1;
  localparam logic [2:0] c_tx         = 3'd2;
  localparam logic [2:0] c_ack        = 3'd3;
  localparam logic [2:0] c_wait_drop  = 3'd4;
  localparam logic [2:0] c_done       = 3'd5;

  localparam logic [CNT_W-1:0] c_full = CNT_W'(NUM_SAMPLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             next_q, next_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic w_tx_start;
  logic w_tx_busy;
  logic w_tx_done;

  // The transmitter latches i_data on the same edge that accepts i_valid, so
  // a final word that is valid for a single cycle is still captured.
  uart_tx_byte #(
    .DATA_SIZE    (DATA_SIZE),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_tx_start),
    .i_data  (i_data),
    .o_tx    (o_tx),
    .o_busy  (w_tx_busy),
    .o_done  (w_tx_done)
  );

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= c_idle;
      count_q <= '0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      next_q  <= next_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    w_tx_start = 1'b0;
    case (state_q)
      c_idle: begin
        if (i_start) begin
          state_d = c_wait_valid;
          count_d = '0;
        end
      end
      c_wait_valid: begin
        if (i_valid && !w_tx_busy) begin
          w_tx_start = 1'b1;
          state_d    = c_tx;
        end else if (!i_valid && i_idle && (count_q != '0)) begin
          // Before the first word the sampler may still be capturing with
          // o_idle high, so idle only ends a dump once something was sent.
          state_d = c_done;
        end
      end
      c_tx: begin
        if (w_tx_done) begin
          count_d = (count_q == c_full) ? count_q : count_q + 1'b1;
          state_d = (count_d == c_full) ? c_done : c_ack;
        end
      end
      c_ack: begin
        state_d = c_wait_drop;
      end
      c_wait_drop: begin
        if (i_idle) begin
          state_d = c_done;
        end else if (!i_valid) begin
          state_d = c_wait_valid;
        end
      end
      c_done: begin
        state_d = c_idle;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  // Output logic, decoded from the next state so the outputs are registered
  // and line up with the state they belong to.
  always_comb begin
    next_d = (state_d == c_ack);
    done_d = (state_d == c_done);
    busy_d = (state_d != c_idle) && (state_d != c_done);
  end

  assign o_next  = next_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_count = count_q;

endmodule : sample_dumper
`default_nettype wire
